branch_predict_unit: RTL and testbench

BRANCH_PREDICT_UNIT -- requirements
Module: branch_predict_unit

---
 rtl/branch_predict_unit.sv | 157 +++++++++++++++
 tb/tb_branch_predict_unit.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/branch_predict_unit.sv
// branch_predict_unit: resolves branches/jumps, registers the outcome and
// keeps a saturating mispredict count. With BRANCH_PREDICT_BHT_EN defined, a
// table of 2-bit counters indexed by pc[IDX_W+1:2] supplies predictions and
// is trained by resolved conditional branches. After reset an INIT sweep
// writes 2'b01 to every entry before requests are accepted.

`ifndef OP_BEQ
`define OP_BEQ    6'h04
`define OP_BNE    6'h05
`define OP_BGEZ   6'h01
`define OP_J      6'h02
`define OP_JAL    6'h03
`define OP_JR     6'h00
`define OP_JALR   6'h00
`define OP_TEQ    6'h00
`define FUNC_JR   6'h08
`define FUNC_JALR 6'h09
`define FUNC_TEQ  6'h34
`endif

module branch_predict_unit #(
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned BHT_DEPTH = 64
) (
  input  logic              in_clk,
  input  logic              in_rst,
  input  logic [31:0]       in_lookup_pc,
  output logic              out_pred_taken,
  input  logic              in_valid,
  input  logic [31:0]       in_pc,
  input  logic [DATA_W-1:0] in_a,
  input  logic [DATA_W-1:0] in_b,
  input  logic [5:0]        in_op,
  input  logic [5:0]        in_func,
  input  logic              in_pred_taken,
  input  logic              in_exception,
  output logic              out_ready,
  output logic              out_valid,
  output logic              out_branch,
  output logic              out_mispredict,
  output logic [31:0]       out_mispredict_cnt
);

  logic taken;
  logic accept;
  logic unused_bits;

  assign accept      = in_valid & out_ready;
  assign unused_bits = ^{in_pc, in_lookup_pc};

  // Branch/jump outcome of the resolving instruction; exceptions force taken
  always_comb begin
    taken = 1'b0;
    if (in_op == `OP_BEQ)                              taken = (in_a == in_b);
    else if (in_op == `OP_BNE)                         taken = (in_a != in_b);
    else if (in_op == `OP_BGEZ)                        taken = ~in_a[DATA_W-1];
    else if (in_op == `OP_J || in_op == `OP_JAL)       taken = 1'b1;
    else if (in_op == `OP_JR && in_func == `FUNC_JR)     taken = 1'b1;
    else if (in_op == `OP_JALR && in_func == `FUNC_JALR) taken = 1'b1;
    else if (in_op == `OP_TEQ && in_func == `FUNC_TEQ)   taken = (in_a == in_b);
    if (in_exception) taken = 1'b1;
  end

  // Registered resolution result and saturating mispredict counter
  always_ff @(posedge in_clk) begin
    if (!in_rst) begin
      out_valid          <= 1'b0;
      out_branch         <= 1'b0;
      out_mispredict     <= 1'b0;
      out_mispredict_cnt <= '0;
    end else begin
      out_valid <= accept;
      if (accept) begin
        out_branch     <= taken;
        out_mispredict <= (taken != in_pred_taken);
        if ((taken != in_pred_taken) && (out_mispredict_cnt != '1))
          out_mispredict_cnt <= out_mispredict_cnt + 32'd1;
      end
    end
  end

`ifdef BRANCH_PREDICT_BHT_EN
  localparam int unsigned IDX_W = $clog2(BHT_DEPTH);

  typedef enum logic {ST_INIT, ST_RUN} state_t;

  state_t           state;
  logic [IDX_W-1:0] init_idx;
  logic [1:0]       bht [BHT_DEPTH];
  logic [IDX_W-1:0] lookup_idx;
  logic [IDX_W-1:0] update_idx;
  logic             cond_branch;
  logic             update;
  logic [1:0]       ctr_cur;
  logic [1:0]       ctr_next;

  assign lookup_idx  = in_lookup_pc[IDX_W+1:2];
  assign update_idx  = in_pc[IDX_W+1:2];
  assign cond_branch = (in_op == `OP_BEQ) || (in_op == `OP_BNE) || (in_op == `OP_BGEZ);
  assign update      = accept & in_rst & cond_branch & ~in_exception;
  assign ctr_cur     = bht[update_idx];

  // Combinational table read gives the pre-update value on an index collision
  assign out_pred_taken = (state == ST_RUN) && bht[lookup_idx][1];

  // Saturating 2-bit counter step
  always_comb begin
    ctr_next = ctr_cur;
    if (taken) begin
      if (ctr_cur != 2'b11) ctr_next = ctr_cur + 2'b01;
    end else if (ctr_cur != 2'b00) begin
      ctr_next = ctr_cur - 2'b01;
    end
  end

  // INIT sweeps the table one entry per cycle, then RUN accepts requests
  always_ff @(posedge in_clk) begin
    if (!in_rst) begin
      state     <= ST_INIT;
      init_idx  <= '0;
      out_ready <= 1'b0;
    end else begin
      case (state)
        ST_INIT: begin
          init_idx <= init_idx + 1'b1;
          if (init_idx == IDX_W'(BHT_DEPTH - 1)) begin
            state     <= ST_RUN;
            out_ready <= 1'b1;
          end
        end
        ST_RUN:  out_ready <= 1'b1;
        default: state <= ST_INIT;
      endcase
    end
  end

  // Table storage: INIT fill or training by resolved conditional branches
  always_ff @(posedge in_clk) begin
    if (state == ST_INIT)
      bht[init_idx] <= 2'b01;
    else if (update)
      bht[update_idx] <= ctr_next;
  end
`else
  logic unused_cfg;

  assign unused_cfg     = (BHT_DEPTH == 0);
  assign out_pred_taken = 1'b0;

  // Without a table, requests are accepted from the first cycle after reset
  always_ff @(posedge in_clk) begin
    if (!in_rst) out_ready <= 1'b0;
    else         out_ready <= 1'b1;
  end
`endif

endmodule

// File: tb/tb_branch_predict_unit.sv
// Self-checking bench for branch_predict_unit (works with or without
// BRANCH_PREDICT_BHT_EN). A behavioural model is advanced right after each
// rising edge; all DUT outputs are compared on the following falling edge.

`ifndef OP_BEQ
`define OP_BEQ    6'h04
`define OP_BNE    6'h05
`define OP_BGEZ   6'h01
`define OP_J      6'h02
`define OP_JAL    6'h03
`define OP_JR     6'h00
`define OP_JALR   6'h00
`define OP_TEQ    6'h00
`define FUNC_JR   6'h08
`define FUNC_JALR 6'h09
`define FUNC_TEQ  6'h34
`endif

module tb_branch_predict_unit;
  localparam int DEPTH = 64;

  logic        clk = 1'b0;
  logic        in_rst;
  logic [31:0] in_lookup_pc;
  logic        out_pred_taken;
  logic        in_valid;
  logic [31:0] in_pc;
  logic [31:0] in_a;
  logic [31:0] in_b;
  logic [5:0]  in_op;
  logic [5:0]  in_func;
  logic        in_pred_taken;
  logic        in_exception;
  logic        out_ready;
  logic        out_valid;
  logic        out_branch;
  logic        out_mispredict;
  logic [31:0] out_mispredict_cnt;

  branch_predict_unit #(.DATA_W(32), .BHT_DEPTH(DEPTH)) dut (
    .in_clk(clk), .in_rst(in_rst), .in_lookup_pc(in_lookup_pc),
    .out_pred_taken(out_pred_taken), .in_valid(in_valid), .in_pc(in_pc),
    .in_a(in_a), .in_b(in_b), .in_op(in_op), .in_func(in_func),
    .in_pred_taken(in_pred_taken), .in_exception(in_exception),
    .out_ready(out_ready), .out_valid(out_valid), .out_branch(out_branch),
    .out_mispredict(out_mispredict), .out_mispredict_cnt(out_mispredict_cnt)
  );

  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;

  // Behavioural model state
  int     m_tbl [DEPTH];
  bit     m_ready;
  int     m_init_pos;
  bit     m_valid, m_branch, m_mis;
  longint m_cnt;
`ifdef BRANCH_PREDICT_BHT_EN
  localparam bit HAS_BHT = 1'b1;
`else
  localparam bit HAS_BHT = 1'b0;
`endif

  function automatic bit ref_taken(input logic [5:0] op, input logic [5:0] fn,
                                   input logic [31:0] a, input logic [31:0] b,
                                   input logic exc);
    if (exc) return 1'b1;
    case (op)
      `OP_BEQ:  return a == b;
      `OP_BNE:  return a != b;
      `OP_BGEZ: return $signed(a) >= 0;
      `OP_J, `OP_JAL: return 1'b1;
      6'h00: begin
        if (fn == `FUNC_JR || fn == `FUNC_JALR) return 1'b1;
        if (fn == `FUNC_TEQ) return a == b;
        return 1'b0;
      end
      default: return 1'b0;
    endcase
  endfunction

  function automatic bit ref_cond(input logic [5:0] op);
    return op == `OP_BEQ || op == `OP_BNE || op == `OP_BGEZ;
  endfunction

  function automatic int idx_of(input logic [31:0] pc);
    return int'((pc >> 2) % DEPTH);
  endfunction

  task automatic model_edge();
    bit t;
    if (!in_rst) begin
      m_ready = 1'b0; m_init_pos = 0;
      m_valid = 1'b0; m_branch = 1'b0; m_mis = 1'b0; m_cnt = 0;
    end else begin
      m_valid = in_valid && m_ready;
      if (m_valid) begin
        t = ref_taken(in_op, in_func, in_a, in_b, in_exception);
        m_branch = t;
        m_mis    = (t != in_pred_taken);
        if (m_mis && m_cnt < 64'hFFFF_FFFF) m_cnt++;
        if (HAS_BHT && ref_cond(in_op) && !in_exception) begin
          if (t) m_tbl[idx_of(in_pc)] = (m_tbl[idx_of(in_pc)] < 3) ? m_tbl[idx_of(in_pc)] + 1 : 3;
          else   m_tbl[idx_of(in_pc)] = (m_tbl[idx_of(in_pc)] > 0) ? m_tbl[idx_of(in_pc)] - 1 : 0;
        end
      end
      if (!HAS_BHT) m_ready = 1'b1;
      else if (!m_ready) begin
        m_tbl[m_init_pos] = 1;
        m_init_pos++;
        if (m_init_pos == DEPTH) m_ready = 1'b1;
      end
    end
  endtask

  task automatic check(input string name, input longint act, input longint exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit exp_pred();
    return HAS_BHT && m_ready && (m_tbl[idx_of(in_lookup_pc)] >= 2);
  endfunction

  task automatic compare_all();
    check("out_valid",          longint'(out_valid),          longint'(m_valid));
    check("out_ready",          longint'(out_ready),          longint'(m_ready));
    check("out_mispredict_cnt", longint'(out_mispredict_cnt), m_cnt);
    check("out_pred_taken",     longint'(out_pred_taken),     longint'(exp_pred()));
    if (m_valid) begin
      check("out_branch",     longint'(out_branch),     longint'(m_branch));
      check("out_mispredict", longint'(out_mispredict), longint'(m_mis));
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    compare_all();
  endtask

  task automatic resolve(input logic [31:0] pc, input logic [31:0] a, input logic [31:0] b,
                         input logic [5:0] op, input logic [5:0] fn,
                         input logic pred, input logic exc);
    in_valid = 1'b1; in_pc = pc; in_lookup_pc = pc; in_a = a; in_b = b;
    in_op = op; in_func = fn; in_pred_taken = pred; in_exception = exc;
    cycle();
    in_valid = 1'b0; in_exception = 1'b0;
  endtask

  task automatic wait_ready(output int n, output bit seen_valid);
    n = 0; seen_valid = 1'b0;
    do begin
      cycle();
      n++;
      seen_valid |= out_valid;
    end while (!out_ready && n < 300);
  endtask

  initial begin
    int  n;
    bit  sv;
    int  exp_n;
    exp_n = HAS_BHT ? DEPTH : 1;
    in_rst = 1'b0; in_valid = 1'b0; in_lookup_pc = '0; in_pc = '0;
    in_a = '0; in_b = '0; in_op = '0; in_func = '0;
    in_pred_taken = 1'b0; in_exception = 1'b0;
    m_ready = 1'b0; m_init_pos = 0; m_valid = 1'b0; m_branch = 1'b0; m_mis = 1'b0; m_cnt = 0;
    foreach (m_tbl[i]) m_tbl[i] = 1;

    cycle(); cycle();
    check("reset_ready", longint'(out_ready), 0);
    check("reset_cnt",   longint'(out_mispredict_cnt), 0);
    check("reset_valid", longint'(out_valid), 0);

    in_rst = 1'b1;
    wait_ready(n, sv);
    check("init_cycles", n, exp_n);
    cycle();

    // BEQ taken three times at 0x100 with carried predictions 0,0,1
    resolve(32'h100, 5, 5, `OP_BEQ, 6'h00, 1'b0, 1'b0);
    check("beq1_branch", out_branch, 1); check("beq1_mis", out_mispredict, 1);
    if (HAS_BHT) check("beq1_pred", out_pred_taken, 1);
    resolve(32'h100, 5, 5, `OP_BEQ, 6'h00, 1'b0, 1'b0);
    check("beq2_mis", out_mispredict, 1);
    resolve(32'h100, 5, 5, `OP_BEQ, 6'h00, 1'b1, 1'b0);
    check("beq3_mis", out_mispredict, 0);
    cycle();
    check("hold_branch", out_branch, 1);

    // BGEZ with negative operand, twice: counter 01 -> 00 -> 00
    resolve(32'h104, 32'h8000_0000, 0, `OP_BGEZ, 6'h00, 1'b1, 1'b0);
    check("bgez_branch", out_branch, 0); check("bgez_mis", out_mispredict, 1);
    resolve(32'h104, 32'h8000_0000, 0, `OP_BGEZ, 6'h00, 1'b1, 1'b0);
    check("bgez_sat_pred", out_pred_taken, 0);

    // JR and excepting BNE: taken, no table change
    resolve(32'h108, 0, 0, `OP_JR, `FUNC_JR, 1'b0, 1'b0);
    check("jr_branch", out_branch, 1);
    check("jr_pred", out_pred_taken, 0);
    resolve(32'h10C, 7, 7, `OP_BNE, 6'h00, 1'b0, 1'b1);
    check("exc_branch", out_branch, 1);
    check("exc_pred", out_pred_taken, 0);
    check("cnt_after6", out_mispredict_cnt, 6);

    // Assorted opcodes
    resolve(32'h110, 3, 3, `OP_TEQ, `FUNC_TEQ, 1'b0, 1'b0);
    check("teq_branch", out_branch, 1);
    resolve(32'h114, 1, 2, `OP_BNE, 6'h00, 1'b0, 1'b0);
    check("bne_branch", out_branch, 1);
    resolve(32'h118, 4, 4, `OP_BNE, 6'h00, 1'b1, 1'b0);
    check("bne_nt_branch", out_branch, 0);
    resolve(32'h11C, 0, 0, `OP_JR, `FUNC_JALR + 6'h01, 1'b0, 1'b0);
    check("bad_func_branch", out_branch, 0);
    resolve(32'h120, 0, 0, `OP_JALR, `FUNC_JALR, 1'b0, 1'b0);
    resolve(32'h124, 0, 0, `OP_J, 6'h00, 1'b0, 1'b0);
    resolve(32'h128, 0, 0, `OP_JAL, 6'h00, 1'b1, 1'b0);
    resolve(32'h12C, 9, 9, 6'h3F, 6'h00, 1'b1, 1'b0);
    check("unknown_branch", out_branch, 0);
    resolve(32'h130, 32'h7FFF_FFFF, 0, `OP_BGEZ, 6'h00, 1'b0, 1'b0);
    check("bgez_pos_branch", out_branch, 1);

    // Same-cycle lookup/update of index 3: pre-update value, then new value
    resolve(32'h00C, 1, 1, `OP_BEQ, 6'h00, 1'b0, 1'b0);
    in_valid = 1'b1; in_pc = 32'h00C; in_lookup_pc = 32'h00C; in_a = 1; in_b = 2;
    in_op = `OP_BEQ; in_func = 6'h00; in_pred_taken = 1'b1;
    #1;
    if (HAS_BHT) check("same_cycle_old", out_pred_taken, 1);
    cycle();
    in_valid = 1'b0;
    check("same_cycle_new", out_pred_taken, 0);

    // Reset mid-RUN with a request pending; requests during INIT are dropped
    in_pc = 32'h100; in_lookup_pc = 32'h100; in_a = 1; in_b = 1;
    in_op = `OP_BEQ; in_pred_taken = 1'b0; in_valid = 1'b1; in_rst = 1'b0;
    cycle();
    check("rst_valid", out_valid, 0);
    check("rst_cnt", out_mispredict_cnt, 0);
    check("rst_ready", out_ready, 0);
    in_rst = 1'b1;
    wait_ready(n, sv);
    in_valid = 1'b0;
    check("reinit_cycles", n, exp_n);
    check("reinit_dropped", sv, 0);
    check("reinit_pred", out_pred_taken, 0);
    cycle(); cycle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end
endmodule
